// File: rtl/branch_resolve.sv
// MIPS conditional-branch resolver: condition decode, target compute and IF redirect handshake.
// Optional BR_RESOLVE_STATS_EN adds resolved/taken branch counters.
module branch_resolve #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic              operands_ready,
  input  logic              greater,
  input  logic              equal,
  input  logic              less,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [15:0]       offset,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              taken,
  output logic              stall_id,
`ifdef BR_RESOLVE_STATS_EN
  output logic [31:0]       br_count,
  output logic [31:0]       taken_count,
`endif
  output logic              flush_if
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    REDIRECT
  } state_t;

  state_t              state;
  logic                cond;
  logic                decide;
  logic [ADDR_W-1:0]   offset_ext;
  logic [ADDR_W-1:0]   target_next;
  logic [ADDR_W-1:0]   target_q;

  always_comb begin
    cond = 1'b0;
    case (br_type)
      3'd0:    cond = equal;
      3'd1:    cond = !equal;
      3'd2:    cond = greater;
      3'd3:    cond = less | equal;
      3'd4:    cond = less;
      3'd5:    cond = greater | equal;
      default: cond = 1'b0;
    endcase
  end

  assign offset_ext  = {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
  assign target_next = pc_plus4 + offset_ext;

  // A branch resolves in IDLE or WAIT_OPS as soon as its operands are final.
  assign decide = (state != REDIRECT) && br_valid && operands_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      target_q <= '0;
      taken    <= 1'b0;
    end else begin
      taken <= 1'b0;
      case (state)
        IDLE, WAIT_OPS: begin
          if (!br_valid) begin
            state <= IDLE;
          end else if (!operands_ready) begin
            state <= WAIT_OPS;
          end else if (cond) begin
            state    <= REDIRECT;
            target_q <= target_next;
            taken    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign redirect_valid  = (state == REDIRECT);
  assign redirect_target = target_q;

  // Gated by reset so the combinational IDLE term cannot hold ID while reset is asserted.
  assign stall_id = reset_n &&
                    (((state == IDLE) && br_valid && !operands_ready) ||
                     (state == WAIT_OPS) || (state == REDIRECT));

  generate
    if (DELAY_SLOT == 0) begin : g_flush
      assign flush_if = (state == REDIRECT) && redirect_ready;
    end else begin : g_no_flush
      assign flush_if = 1'b0;
    end
  endgenerate

`ifdef BR_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (decide) begin
      br_count <= br_count + 32'd1;
      if (cond) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: one DUT per DELAY_SLOT setting, driven in lockstep.
module tb_branch_resolve;

  logic        clk;
  logic        reset_n;
  logic        br_valid;
  logic [2:0]  br_type;
  logic        operands_ready;
  logic        greater, equal, less;
  logic [31:0] pc_plus4;
  logic [15:0] offset;
  logic        redirect_ready;

  logic        rv1, rv0, tk1, tk0, st1, st0, fl1, fl0;
  logic [31:0] tg1, tg0;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] bc1, tc1, bc0, tc0;
`endif

  int errors = 0;
  int checks = 0;
  int fl0_cnt = 0;
  int fl1_cnt = 0;

  branch_resolve #(.ADDR_W(32), .DELAY_SLOT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .br_type(br_type),
    .operands_ready(operands_ready), .greater(greater), .equal(equal), .less(less),
    .pc_plus4(pc_plus4), .offset(offset), .redirect_ready(redirect_ready),
    .redirect_valid(rv1), .redirect_target(tg1), .taken(tk1), .stall_id(st1),
`ifdef BR_RESOLVE_STATS_EN
    .br_count(bc1), .taken_count(tc1),
`endif
    .flush_if(fl1)
  );

  branch_resolve #(.ADDR_W(32), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .br_valid(br_valid), .br_type(br_type),
    .operands_ready(operands_ready), .greater(greater), .equal(equal), .less(less),
    .pc_plus4(pc_plus4), .offset(offset), .redirect_ready(redirect_ready),
    .redirect_valid(rv0), .redirect_target(tg0), .taken(tk0), .stall_id(st0),
`ifdef BR_RESOLVE_STATS_EN
    .br_count(bc0), .taken_count(tc0),
`endif
    .flush_if(fl0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (fl0) fl0_cnt++;
    if (fl1) fl1_cnt++;
  end

  task automatic drive_br(input logic [2:0] t, input logic g, input logic e, input logic l,
                          input logic [31:0] pc, input logic [15:0] off, input logic rdy);
    br_valid = 1'b1; br_type = t; greater = g; equal = e; less = l;
    pc_plus4 = pc; offset = off; operands_ready = rdy;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if ({rv1, tk1, st1, fl1, rv0, tk0, st0, fl0} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b expected 00000000", {rv1, tk1, st1, fl1, rv0, tk0, st0, fl0});
    end
    checks++;
    if (tg1 !== 32'h0 || tg0 !== 32'h0) begin
      errors++; $display("FAIL reset_target got %h/%h expected 00000000", tg1, tg0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_beq;
    int f0;
    f0 = fl0_cnt;
    drive_br(3'd0, 1'b0, 1'b1, 1'b0, 32'h0040_0004, 16'h0003, 1'b1);
    #1;
    checks++;
    if (st1 !== 1'b0) begin errors++; $display("FAIL beq_no_stall got %b expected 0", st1); end
    @(negedge clk);
    checks++;
    if ({rv1, tk1, st1} !== 3'b111) begin
      errors++; $display("FAIL beq_redirect valid/taken/stall got %b expected 111", {rv1, tk1, st1});
    end
    checks++;
    if (tg1 !== 32'h0040_0010) begin errors++; $display("FAIL beq_target got %h expected 00400010", tg1); end
    br_valid = 1'b0; redirect_ready = 1'b1;
    #1;
    checks++;
    if (fl0 !== 1'b1 || fl1 !== 1'b0) begin
      errors++; $display("FAIL beq_flush got ds0=%b ds1=%b expected ds0=1 ds1=0", fl0, fl1);
    end
    @(negedge clk);
    redirect_ready = 1'b0;
    checks++;
    if ({rv1, tk1, st1, fl0} !== 4'b0000) begin
      errors++; $display("FAIL beq_release got %b expected 0000", {rv1, tk1, st1, fl0});
    end
    checks++;
    if (fl0_cnt - f0 != 1) begin errors++; $display("FAIL beq_flush_once got %0d expected 1", fl0_cnt - f0); end
  endtask

  task automatic test_bne_not_taken;
    drive_br(3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 16'h0004, 1'b1);
    #1;
    checks++;
    if (st1 !== 1'b0) begin errors++; $display("FAIL bne_stall_decide got %b expected 0", st1); end
    @(negedge clk);
    checks++;
    if ({rv1, tk1, st1} !== 3'b000) begin
      errors++; $display("FAIL bne_no_redirect got %b expected 000", {rv1, tk1, st1});
    end
    br_valid = 1'b0;
  endtask

  task automatic test_bltz_wrap;
    drive_br(3'd4, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 16'hFFFF, 1'b1);
    @(negedge clk);
    checks++;
    if (rv1 !== 1'b1 || tg1 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL bltz_wrap got valid=%b target=%h expected valid=1 target=fffffffc", rv1, tg1);
    end
    br_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
  endtask

  task automatic test_wait_ops;
    drive_br(3'd5, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (st1 !== 1'b1 || rv1 !== 1'b0) begin
        errors++; $display("FAIL wait_stall cyc%0d got stall=%b valid=%b expected stall=1 valid=0", i, st1, rv1);
      end
      @(negedge clk);
    end
    operands_ready = 1'b1;
    #1;
    checks++;
    if (st1 !== 1'b1) begin errors++; $display("FAIL wait_decide_stall got %b expected 1", st1); end
    @(negedge clk);
    br_valid = 1'b0;
    checks++;
    if ({rv1, tk1, st1} !== 3'b111 || tg1 !== 32'h0000_1040) begin
      errors++; $display("FAIL wait_redirect got %b target=%h expected 111 target=00001040", {rv1, tk1, st1}, tg1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({rv1, tk1, st1} !== 3'b101 || tg1 !== 32'h0000_1040) begin
        errors++; $display("FAIL hold_redirect cyc%0d got %b target=%h expected 101 target=00001040", i, {rv1, tk1, st1}, tg1);
      end
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    checks++;
    if ({rv1, st1} !== 2'b00) begin errors++; $display("FAIL wait_accept got %b expected 00", {rv1, st1}); end
  endtask

  task automatic test_squash;
    drive_br(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 16'h0001, 1'b0);
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    checks++;
    if (st1 !== 1'b1) begin errors++; $display("FAIL squash_waitops_stall got %b expected 1", st1); end
    @(negedge clk);
    operands_ready = 1'b1;
    checks++;
    if ({rv1, tk1, st1} !== 3'b000) begin
      errors++; $display("FAIL squash_idle got %b expected 000", {rv1, tk1, st1});
    end
  endtask

  task automatic test_conditions;
    // {type, greater, equal, less, expected taken}
    logic [6:0] vec [12] = '{
      {3'd0, 3'b000, 1'b0}, {3'd1, 3'b000, 1'b1}, {3'd2, 3'b100, 1'b1},
      {3'd2, 3'b010, 1'b0}, {3'd3, 3'b001, 1'b1}, {3'd3, 3'b010, 1'b1},
      {3'd3, 3'b100, 1'b0}, {3'd4, 3'b010, 1'b0}, {3'd5, 3'b010, 1'b1},
      {3'd5, 3'b001, 1'b0}, {3'd6, 3'b111, 1'b0}, {3'd7, 3'b111, 1'b0}};
    logic [6:0] v;
    for (int i = 0; i < 12; i++) begin
      v = vec[i];
      drive_br(v[6:4], v[3], v[2], v[1], 32'h0000_0100, 16'h0002, 1'b1);
      @(negedge clk);
      br_valid = 1'b0;
      checks++;
      if (rv1 !== v[0] || tk1 !== v[0]) begin
        errors++; $display("FAIL cond type=%0d gel=%b got valid=%b taken=%b expected %b", v[6:4], v[3:1], rv1, tk1, v[0]);
      end
      if (v[0]) begin
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset;
    drive_br(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 16'h0008, 1'b1);
    @(negedge clk);
    br_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rv1, st1, tk1, rv0, st0, tk0} !== 6'b000000 || tg1 !== 32'h0) begin
      errors++; $display("FAIL async_reset got %b target=%h expected 000000 target=00000000", {rv1, st1, tk1, rv0, st0, tk0}, tg1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rv1, st1, tk1} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle got %b expected 000", {rv1, st1, tk1});
    end
  endtask

  task automatic test_back_to_back_stats;
    int f0, f1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    f0 = fl0_cnt; f1 = fl1_cnt;
    drive_br(3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 16'h0001, 1'b1);
    @(negedge clk);
    br_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    drive_br(3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 16'h0001, 1'b1);
    @(negedge clk);
    drive_br(3'd2, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 16'h0002, 1'b1);
    @(negedge clk);
    br_valid = 1'b0;
    checks++;
    if (rv0 !== 1'b1 || tg0 !== 32'h0000_5008) begin
      errors++; $display("FAIL b2b_redirect got valid=%b target=%h expected 1 00005008", rv0, tg0);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fl0_cnt - f0 != 2 || fl1_cnt - f1 != 0) begin
      errors++; $display("FAIL flush_count got ds0=%0d ds1=%0d expected ds0=2 ds1=0", fl0_cnt - f0, fl1_cnt - f1);
    end
`ifdef BR_RESOLVE_STATS_EN
    checks++;
    if (bc0 !== 32'd3 || tc0 !== 32'd2 || bc1 !== 32'd3 || tc1 !== 32'd2) begin
      errors++; $display("FAIL stats got br=%0d/%0d taken=%0d/%0d expected br=3 taken=2", bc0, bc1, tc0, tc1);
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0; br_valid = 1'b0; br_type = 3'd0; operands_ready = 1'b0;
    greater = 1'b0; equal = 1'b0; less = 1'b0; pc_plus4 = '0; offset = '0;
    redirect_ready = 1'b0;
    test_reset;
    test_beq;
    test_bne_not_taken;
    test_bltz_wrap;
    test_wait_ops;
    test_squash;
    test_conditions;
    test_async_reset;
    test_back_to_back_stats;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
